// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// State encoding, IF/ID bundle and default parameter values.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halt;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc_plus4: 32'h0,
    valid:    1'b0,
    halt:     1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Hold has priority over flush, flush over load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= IF_ID_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register, halt detection and drain.
// All outputs are registered.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter logic [31:0] HALT_INSTR   = DEF_HALT_INSTR,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Instr_F,
  input  logic        Stall,
  input  logic        BranchTaken_D,
  input  logic [31:0] BranchTarget_D,
  input  logic        Jump_D,
  input  logic [31:0] JumpTarget_D,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic        Halt_D,
  output logic        Finished,
  output logic [31:0] FetchCount
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [7:0]  drain_cnt;
  logic        run;
  logic        drain;
  logic        go;
  logic        redirect;
  logic        is_halt;
  logic [31:0] pc_plus4;
  logic        rg_hold;
  logic        rg_flush;
  logic        rg_load;
  if_id_t      rg_d;
  if_id_t      rg_q;

  assign run      = (state == ST_RUN);
  assign drain    = (state == ST_DRAIN);
  assign go       = !Stall;
  assign redirect = Jump_D | BranchTaken_D;
  assign is_halt  = (Instr_F == HALT_INSTR);
  assign pc_plus4 = PC_F + 32'd4;

  // DONE freezes IF/ID regardless of Stall
  assign rg_hold  = Stall | (state == ST_DONE);
  assign rg_flush = go & ((run & redirect) | drain);
  assign rg_load  = go & run & !redirect;

  assign rg_d = '{
    instr:    Instr_F,
    pc_plus4: pc_plus4,
    valid:    1'b1,
    halt:     is_halt
  };

  if_id_reg u_if_id (
    .clk   (CLK),
    .rst_n (RST_N),
    .hold  (rg_hold),
    .flush (rg_flush),
    .load  (rg_load),
    .d     (rg_d),
    .q     (rg_q)
  );

  assign Instr_D   = rg_q.instr;
  assign PCPlus4_D = rg_q.pc_plus4;
  assign Valid_D   = rg_q.valid;
  assign Halt_D    = rg_q.halt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PC_F       <= RESET_PC;
      state      <= ST_RUN;
      drain_cnt  <= '0;
      Finished   <= 1'b0;
      FetchCount <= '0;
    end else if (go) begin
      unique case (state)
        ST_RUN: begin
          if (Jump_D) begin
            PC_F <= JumpTarget_D;
          end else if (BranchTaken_D) begin
            PC_F <= BranchTarget_D;
          end else begin
            FetchCount <= FetchCount + 32'd1;
            if (is_halt) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              PC_F <= pc_plus4;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 8'd1;
          if (drain_cnt == DRAIN_LAST) begin
            state    <= ST_DONE;
            Finished <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table through a scoreboard,
// plus a PC wrap sequence on a second instance.
module tb_fetch_stage;

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        hl;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        h;
    logic        f;
    logic        chk_p4;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [31:0] H = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] bt = '0;
  logic        jmp = 1'b0;
  logic [31:0] jt = '0;
  logic        hl = 1'b0;

  logic [31:0] instr_f, pc_f, instr_d, p4_d, cnt;
  logic        valid_d, halt_d, fin;
  logic [31:0] instr_f2, pc_f2, instr_d2, p4_d2, cnt2;
  logic        valid_d2, halt_d2, fin2;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  assign instr_f  = hl ? H : mem(pc_f);
  assign instr_f2 = mem(pc_f2);

  fetch_stage dut (
    .CLK(clk), .RST_N(rst_n), .Instr_F(instr_f), .Stall(stall),
    .BranchTaken_D(br), .BranchTarget_D(bt),
    .Jump_D(jmp), .JumpTarget_D(jt),
    .PC_F(pc_f), .Instr_D(instr_d), .PCPlus4_D(p4_d),
    .Valid_D(valid_d), .Halt_D(halt_d), .Finished(fin),
    .FetchCount(cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(clk), .RST_N(rst2_n), .Instr_F(instr_f2), .Stall(stall),
    .BranchTaken_D(br), .BranchTarget_D(bt),
    .Jump_D(jmp), .JumpTarget_D(jt),
    .PC_F(pc_f2), .Instr_D(instr_d2), .PCPlus4_D(p4_d2),
    .Valid_D(valid_d2), .Halt_D(halt_d2), .Finished(fin2),
    .FetchCount(cnt2)
  );

  function automatic vec_t mk(
    input logic r, s, b, input logic [31:0] bta,
    input logic j, input logic [31:0] jta, input logic hlt,
    input logic [31:0] pc, ins, p4,
    input logic v, h, f, input logic [31:0] c
  );
    vec_t t;
    t.r = r; t.s = s; t.b = b; t.bt = bta;
    t.j = j; t.jt = jta; t.hl = hlt;
    t.pc = pc; t.ins = ins; t.p4 = p4;
    t.v = v; t.h = h; t.f = f; t.cnt = c;
    t.chk_p4 = v | !r;
    return t;
  endfunction

  task automatic chk(input int idx, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s act=%h exp=%h", idx, nm, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    vec_t e;
    rst_n = t.r; stall = t.s; br = t.b; bt = t.bt;
    jmp = t.j; jt = t.jt; hl = t.hl;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(idx, "pc_f", pc_f, e.pc);
    chk(idx, "instr_d", instr_d, e.ins);
    if (e.chk_p4) chk(idx, "pcplus4_d", p4_d, e.p4);
    chk(idx, "valid_d", 32'(valid_d), 32'(e.v));
    chk(idx, "halt_d", 32'(halt_d), 32'(e.h));
    chk(idx, "finished", 32'(fin), 32'(e.f));
    chk(idx, "fetchcount", cnt, e.cnt);
  endtask

  initial begin
    // r s b bt j jt hl | pc ins p4 v h f cnt
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 4,mem(0),4,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 8,mem(4),8,1,0,0,2));
    tbl.push_back(mk(1,1,1,'h40,0,0,0, 8,mem(4),8,1,0,0,2));
    tbl.push_back(mk(1,1,1,'h40,0,0,0, 8,mem(4),8,1,0,0,2));
    tbl.push_back(mk(1,0,1,'h40,0,0,0, 'h40,0,0,0,0,0,2));
    tbl.push_back(mk(1,0,0,0,0,0,0, 'h44,mem('h40),'h44,1,0,0,3));
    tbl.push_back(mk(1,0,1,'h200,1,'h100,0, 'h100,0,0,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0, 'h104,mem('h100),'h104,1,0,0,4));
    tbl.push_back(mk(1,0,1,'h80,0,0,1, 'h80,0,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0,0,0, 'h84,mem('h80),'h84,1,0,0,5));
    tbl.push_back(mk(1,0,0,0,1,'h8,0, 'h8,0,0,0,0,0,5));
    tbl.push_back(mk(1,0,0,0,0,0,0, 'hC,mem('h8),'hC,1,0,0,6));
    tbl.push_back(mk(1,0,0,0,0,0,0, 'h10,mem('hC),'h10,1,0,0,7));
    tbl.push_back(mk(1,0,0,0,0,0,1, 'h10,H,'h14,1,1,0,8));
    tbl.push_back(mk(1,0,0,0,0,0,1, 'h10,0,0,0,0,0,8));
    tbl.push_back(mk(1,1,0,0,0,0,1, 'h10,0,0,0,0,0,8));
    tbl.push_back(mk(1,0,0,0,0,0,1, 'h10,0,0,0,0,0,8));
    tbl.push_back(mk(1,0,1,'h300,0,0,1, 'h10,0,0,0,0,0,8));
    tbl.push_back(mk(1,0,0,0,0,0,1, 'h10,0,0,0,0,1,8));
    tbl.push_back(mk(1,0,1,'h300,1,'h200,1, 'h10,0,0,0,0,1,8));
    tbl.push_back(mk(1,1,0,0,1,'h200,1, 'h10,0,0,0,0,1,8));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 4,mem(0),4,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,1, 4,H,8,1,1,0,2));
    tbl.push_back(mk(1,0,0,0,0,0,1, 4,0,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 4,mem(0),4,1,0,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // PC wrap on the second instance
    stall = 0; br = 0; jmp = 0; hl = 0;
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    chk(100, "wrap_reset_pc", pc_f2, 32'hFFFF_FFFC);
    chk(100, "wrap_reset_valid", 32'(valid_d2), 32'd0);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    chk(101, "wrap_pc", pc_f2, 32'h0);
    chk(101, "wrap_pcplus4", p4_d2, 32'h0);
    chk(101, "wrap_instr", instr_d2, 32'hA5A5_FFFC);
    chk(101, "wrap_valid", 32'(valid_d2), 32'd1);
    chk(101, "wrap_count", cnt2, 32'd1);
    chk(101, "wrap_halt", 32'(halt_d2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Owns the program counter and the IF/ID pipeline register of the 5-stage MIPS pipeline.
- Sits directly upstream of the hazard detection unit. It consumes that unit's Stall output and the ID-stage branch/jump resolution.
- Produces the instruction and PC+4 presented to decode.
- Detects the halt instruction, freezes fetch, counts out the pipeline drain, then asserts Finished.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that terminates fetch.
- DRAIN_CYCLES, 4, non-stalled cycles after the halt enters ID before Finished asserts.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- Instr_F  in  32  instruction-memory read data for address PC_F (combinational memory).
- Stall  in  1  hold request from hazard detection.
- BranchTaken_D  in  1  branch in ID resolved taken.
- BranchTarget_D  in  32  branch target address.
- Jump_D  in  1  J/JAL in ID.
- JumpTarget_D  in  32  jump target address.
- PC_F  out  32  current fetch address to instruction memory.
- Instr_D  out  32  IF/ID instruction.
- PCPlus4_D  out  32  IF/ID PC+4.
- Valid_D  out  1  IF/ID holds a real (non-bubble) instruction.
- Halt_D  out  1  IF/ID holds the halt instruction.
- Finished  out  1  drain complete; sticky until reset.
- FetchCount  out  32  number of valid instructions written into IF/ID.

Behaviour:
- Reset (RST_N=0 at edge):
  - PC_F=RESET_PC; Instr_D=0 (NOP); PCPlus4_D=0; Valid_D=0; Halt_D=0; Finished=0; FetchCount=0.
  - state=RUN; drain counter=0.
  - Reset asserted mid-drain or in DONE returns to RUN the same edge.
- States: RUN, DRAIN, DONE. Encoding lives in the package.
- Per-edge priority in RUN, highest first:
  - Stall=1: PC_F, IF/ID and FetchCount hold. Redirect inputs are ignored, because branch operands are not valid while stalled.
  - Jump_D=1: PC_F<=JumpTarget_D. IF/ID flushed (Instr_D=0, Valid_D=0, Halt_D=0). Jump wins if BranchTaken_D is also 1.
  - BranchTaken_D=1: PC_F<=BranchTarget_D; IF/ID flushed. A halt fetched in the same cycle is squashed; no state change.
  - Instr_F==HALT_INSTR: IF/ID<=halt (Valid_D=1, Halt_D=1, PCPlus4_D=PC_F+4); PC_F holds; FetchCount+1; state->DRAIN; counter=0.
  - Otherwise: IF/ID<={Instr_F, PC_F+4, valid}; PC_F<=PC_F+4; FetchCount+1.
- DRAIN:
  - PC_F frozen. Redirect inputs are ignored (no branch can be older than the halt in ID).
  - Stall=1: IF/ID and counter hold.
  - Stall=0: IF/ID<=bubble (Instr_D=0, Valid_D=0, Halt_D=0); counter+1.
  - When counter reaches DRAIN_CYCLES-1 on a non-stalled edge: state->DONE; Finished=1 from the next cycle.
- DONE: all state frozen; Finished=1; IF/ID stays bubble; Stall and redirects are ignored.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag. FetchCount wraps modulo 2^32.
- Halt_D implies Valid_D.
- The block has no combinational path from any input to any output. PC_F, Instr_D and all other outputs are registers.

Decomposition:
- Package fetch_pkg:
  - state typedef (RUN/DRAIN/DONE, 2-bit).
  - NOP_INSTR=32'h0.
  - Default HALT_INSTR and RESET_PC constants.
- Sub-module if_id_reg: the IF/ID register with hold/flush/load controls and its own reset. The parent owns the PC, the FSM and FetchCount.

Test Plan:
- Straight-line fetch: reset, then 3 cycles with Stall=0 and no redirects. Expect PC_F sequence 0,4,8,C; PCPlus4_D=4,8,C; FetchCount=3; Valid_D=1.
- Stall hold: with PC_F=8, Stall=1 for 2 cycles and BranchTaken_D=1 with target 0x40. Expect PC_F=8, Instr_D unchanged and FetchCount unchanged during the stall. After Stall drops (branch still asserted), expect PC_F=0x40 and Valid_D=0 on the next edge.
- Simultaneous redirect: Jump_D=1 to 0x100 and BranchTaken_D=1 to 0x200 in the same cycle. Expect PC_F=0x100 and an IF/ID bubble.
- Halt squash: BranchTaken_D=1 to 0x80 while Instr_F=32'hFFFF_FFFF. Expect PC_F=0x80, Halt_D=0, state stays RUN.
- Halt drain: halt fetched at PC 0x10, then one Stall cycle during drain. Expect Halt_D=1 for one cycle, PC_F fixed at 0x10, and Finished=1 exactly 5 cycles after the halt enters ID (DRAIN_CYCLES=4 plus 1 stall cycle). Finished stays set afterwards despite redirects.
- Reset mid-drain and wrap: assert RST_N=0 during DRAIN and expect all reset values with state=RUN. Separately, RESET_PC=32'hFFFF_FFFC: after one fetch, expect PC_F=0 and PCPlus4_D=0.
